// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-bit two-flop synchroniser, debounce filter,
// registered press/release strobes and a held-button auto-repeat strobe.
module btn_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_repeat,
  output logic [NUM_BTN-1:0] btn_event
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
  localparam logic [RP_W-1:0] RP_DELAY_C  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_PERIOD_C = RP_W'(REPEAT_PERIOD);
  localparam logic [RP_W-1:0] RP_ONE      = RP_W'(1);
  localparam logic            RP_EN       = (REPEAT_DELAY != 0);

  logic [NUM_BTN-1:0]           sync1_q, sync2_q;
  logic [NUM_BTN-1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [NUM_BTN-1:0]           level_q, level_d;
  logic [NUM_BTN-1:0]           press_q, press_d;
  logic [NUM_BTN-1:0]           release_q, release_d;
  logic [NUM_BTN-1:0]           repeat_q, repeat_d;
  logic [NUM_BTN-1:0][RP_W-1:0] rp_cnt_q, rp_cnt_d;
  logic [NUM_BTN-1:0]           rp_first_q, rp_first_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // A differing sample must persist DEBOUNCE_CYCLES times in a row; any
  // agreement with the current level restarts the count.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_cnt_d[i]  = '0;
        level_d[i]   = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  // Repeat phase keys off the next level so a release suppresses a repeat
  // that would otherwise land in the same cycle.
  always_comb begin
    rp_cnt_d   = rp_cnt_q;
    rp_first_d = rp_first_q;
    repeat_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!RP_EN || !level_d[i]) begin
        rp_cnt_d[i]   = '0;
        rp_first_d[i] = 1'b0;
      end else if (press_d[i]) begin
        rp_cnt_d[i]   = RP_ONE;
        rp_first_d[i] = 1'b1;
      end else if (rp_cnt_q[i] == (rp_first_q[i] ? RP_DELAY_C : RP_PERIOD_C)) begin
        repeat_d[i]   = 1'b1;
        rp_cnt_d[i]   = RP_ONE;
        rp_first_d[i] = 1'b0;
      end else begin
        rp_cnt_d[i] = rp_cnt_q[i] + RP_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q   <= '0;
      level_q    <= '0;
      press_q    <= '0;
      release_q  <= '0;
      repeat_q   <= '0;
      rp_cnt_q   <= '0;
      rp_first_q <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
      rp_cnt_q   <= rp_cnt_d;
      rp_first_q <= rp_first_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;
  assign btn_event   = press_q | repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: strobes are scored against an ordered
// queue of {cycle, bit, kind} entries pushed as each stimulus step is driven.
module tb_btn_conditioner;

  localparam int NB = 2;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int EW = 35;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_event;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] front;
  logic [EW-1:0] got;
  logic [EW-1:0] want;

  btn_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat),
    .btn_event  (btn_event)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 press, 1 release, 2 repeat, 3 event
  function automatic logic [EW-1:0] mk(int c, int b, int k);
    logic [31:0] cv;
    logic [31:0] bv;
    logic [31:0] kv;
    cv = c;
    bv = b;
    kv = k;
    return {cv, bv[0], kv[1:0]};
  endfunction

  function automatic logic obs_bit(int b, int k);
    case (k)
      0:       return btn_press[b];
      1:       return btn_release[b];
      2:       return btn_repeat[b];
      default: return btn_event[b];
    endcase
  endfunction

  task automatic push_exp(int c, int b, int k);
    logic [EW-1:0] v;
    int i;
    v = mk(c, b, k);
    i = 0;
    while (i < exp_q.size() && exp_q[i] < v) i++;
    exp_q.insert(i, v);
  endtask

  // Press at p, repeats at p+RD, then every RP, all strictly before r;
  // release strobe at r when rel is set.
  task automatic expect_hold(int b, int p, int r, bit rel);
    push_exp(p, b, 0);
    push_exp(p, b, 3);
    for (int t = p + RD; t < r; t += RP) begin
      push_exp(t, b, 2);
      push_exp(t, b, 3);
    end
    if (rel) push_exp(r, b, 1);
  endtask

  // driver helpers: inputs change 1 time unit after the falling edge
  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_until(int n);
    while (cyc < n) step(1);
  endtask

  task automatic chk(string tag, logic [NB-1:0] obs, logic [NB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_level"},   btn_level,   2'b00);
    chk({tag, "_press"},   btn_press,   2'b00);
    chk({tag, "_release"}, btn_release, 2'b00);
    chk({tag, "_repeat"},  btn_repeat,  2'b00);
    chk({tag, "_event"},   btn_event,   2'b00);
  endtask

  // scoreboard monitor: every strobe seen must be the next queued entry
  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        checks++;
        assert (int'(front[EW-1:3]) >= cyc) else begin
          errors++;
          $error("FAIL missed_strobe: at cycle %0d, expected bit %0d kind %0d at cycle %0d",
                 cyc, front[2], front[1:0], front[EW-1:3]);
          exp_q.delete(0);
        end
      end
      for (int b = 0; b < NB; b++) begin
        for (int k = 0; k < 4; k++) begin
          if (obs_bit(b, k)) begin
            got = mk(cyc, b, k);
            if (exp_q.size() > 0) begin
              want = exp_q[0];
              exp_q.delete(0);
            end else begin
              want = '1;
            end
            checks++;
            assert (got === want) else begin
              errors++;
              $error("FAIL strobe: got cycle %0d bit %0d kind %0d, expected cycle %0d bit %0d kind %0d",
                     got[EW-1:3], got[2], got[1:0], want[EW-1:3], want[2], want[1:0]);
            end
          end
        end
      end
    end
  end

  int n0, s, a, b0, c, p, n, m;

  initial begin
    reset   = 1'b1;
    btn_raw = 2'b11;

    // 1: reset with both held, then qualification of both
    step(3);
    chk_zero("t1_in_reset");
    n0 = cyc;
    reset = 1'b0;
    expect_hold(0, n0 + 6, n0 + 14, 1'b1);
    expect_hold(1, n0 + 6, n0 + 14, 1'b1);
    step(1);
    chk_zero("t1_first_after");
    wait_until(n0 + 5);
    chk("t1_level_pre", btn_level, 2'b00);
    step(1);
    chk("t1_level_up", btn_level, 2'b11);
    wait_until(n0 + 8);
    btn_raw = 2'b00;
    wait_until(n0 + 13);
    chk("t1_level_hold", btn_level, 2'b11);
    step(1);
    chk("t1_level_down", btn_level, 2'b00);

    // 2: bounce on bit 0 before settling high
    step(2);
    btn_raw[0] = 1'b1; step(3);
    btn_raw[0] = 1'b0; step(1);
    btn_raw[0] = 1'b1; step(2);
    btn_raw[0] = 1'b0; step(1);
    s = cyc;
    btn_raw[0] = 1'b1;
    expect_hold(0, s + 6, s + 14, 1'b1);
    wait_until(s + 5);
    chk("t2_level_pre", btn_level, 2'b00);
    step(1);
    chk("t2_level_up", btn_level, 2'b01);
    wait_until(s + 8);
    btn_raw[0] = 1'b0;
    wait_until(s + 14);
    chk("t2_level_down", btn_level, 2'b00);

    // 3/4: hold bit 1, glitches on both bits, release where a repeat would land
    a = cyc + 2;
    wait_until(a);
    btn_raw[1] = 1'b1;
    expect_hold(1, a + 6, a + 46, 1'b1);
    wait_until(a + 20);
    btn_raw[1] = 1'b0; step(3);
    btn_raw[1] = 1'b1;
    wait_until(a + 30);
    btn_raw[0] = 1'b1; step(2);
    btn_raw[0] = 1'b0;
    wait_until(a + 40);
    btn_raw[1] = 1'b0;
    wait_until(a + 45);
    chk("t4_level_hold", btn_level, 2'b10);
    step(1);
    chk("t4_level_down", btn_level, 2'b00);

    // 5: staggered presses and releases
    b0 = cyc + 2;
    wait_until(b0);
    btn_raw[0] = 1'b1;
    step(2);
    btn_raw[1] = 1'b1;
    expect_hold(0, b0 + 6, b0 + 21, 1'b1);
    expect_hold(1, b0 + 8, b0 + 36, 1'b1);
    wait_until(b0 + 7);
    chk("t5_level_b0", btn_level, 2'b01);
    step(1);
    chk("t5_level_both", btn_level, 2'b11);
    wait_until(b0 + 15);
    btn_raw[0] = 1'b0;
    wait_until(b0 + 21);
    chk("t5_level_b0_rel", btn_level, 2'b10);
    wait_until(b0 + 30);
    btn_raw[1] = 1'b0;
    wait_until(b0 + 36);
    chk("t5_level_b1_rel", btn_level, 2'b00);

    // 6: reset in the repeat phase, then re-qualification while still held
    c = cyc + 2;
    wait_until(c);
    btn_raw[0] = 1'b1;
    p = c + 6;
    n = p + 15;
    expect_hold(0, p, n + 1, 1'b0);
    wait_until(n);
    chk("t6_level_before", btn_level, 2'b01);
    reset = 1'b1;
    #1;
    chk_zero("t6_reset_now");
    step(2);
    chk_zero("t6_in_reset");
    m = cyc;
    reset = 1'b0;
    expect_hold(0, m + 6, m + 21, 1'b1);
    step(1);
    chk_zero("t6_first_after");
    wait_until(m + 5);
    chk("t6_level_pre", btn_level, 2'b00);
    step(1);
    chk("t6_level_up", btn_level, 2'b01);
    wait_until(m + 15);
    btn_raw[0] = 1'b0;
    wait_until(m + 21);
    chk("t6_level_down", btn_level, 2'b00);

    // drain and report
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
    step(4);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_empty: got %0d pending entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the raw push-button inputs before they reach game_logic as btn.
- For each button: synchronises it into the clk domain, debounces it, and produces:
  - a clean level,
  - single-cycle press and release strobes,
  - an auto-repeat strobe, so a held button gives continuous player movement at a controlled rate.
- Buttons are processed independently.

Parameters:
- NUM_BTN, 2, number of buttons conditioned in parallel.
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a changed synchronised input must hold before btn_level follows it (5 ms at 100 MHz); legal range is 1 or more.
- REPEAT_DELAY, 25000000, cycles from the press strobe to the first repeat strobe while held; 0 disables auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat strobes while held; legal range is 1 or more.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  raw, asynchronous, bouncing button inputs.
- btn_level  output  NUM_BTN  debounced level per button.
- btn_press  output  NUM_BTN  one-cycle strobe when btn_level rises.
- btn_release  output  NUM_BTN  one-cycle strobe when btn_level falls.
- btn_repeat  output  NUM_BTN  one-cycle auto-repeat strobe while held.
- btn_event  output  NUM_BTN  btn_press OR btn_repeat, per bit; this is the movement request to game_logic.

Behaviour:
- Reset (asynchronous, active-high): every flop clears. All outputs are 0 while reset is asserted and on the first cycle after it releases. This covers sync stages, debounce counters, stable levels, repeat counters and strobes.
- Synchroniser: two-flop chain per bit; sync = btn_raw delayed two edges. All later logic uses sync only.
- Debounce, per bit, with counter db_cnt of width $clog2(DEBOUNCE_CYCLES+1):
  - If sync == btn_level: db_cnt <= 0.
  - Else if db_cnt == DEBOUNCE_CYCLES-1: btn_level <= sync and db_cnt <= 0.
  - Else: db_cnt <= db_cnt+1.
  - Any return of sync to btn_level before the count completes restarts the count from 0. Glitches shorter than DEBOUNCE_CYCLES are fully rejected.
- Latency: a clean input change first sampled at edge k appears on btn_level after edge k+DEBOUNCE_CYCLES+1.
- Press/release strobes:
  - btn_press and btn_release are registered and asserted in exactly the first cycle btn_level holds its new value.
  - They are never asserted together for the same bit.
  - Each lasts exactly 1 cycle.
- Auto-repeat, per bit, counter rp_cnt of width sized for max(REPEAT_DELAY, REPEAT_PERIOD), with phase flag rp_first:
  - On the press edge: rp_cnt <= 1 and rp_first <= 1.
  - While btn_level = 1, with target T = REPEAT_DELAY if rp_first else REPEAT_PERIOD:
    - If rp_cnt == T: btn_repeat pulses for 1 cycle, rp_cnt <= 1, rp_first <= 0.
    - Else: rp_cnt increments.
  - Result: the first repeat comes REPEAT_DELAY cycles after the press cycle, then one every REPEAT_PERIOD cycles.
  - When btn_level = 0: rp_cnt <= 0 and no repeat strobes. Release stops repeats in the same cycle btn_level falls.
  - REPEAT_DELAY = 0: btn_repeat is held at 0.
- btn_event is combinational OR of the registered btn_press and btn_repeat; it carries no extra latency.
- Buttons are fully independent: simultaneous presses, staggered presses, and one bouncing while another is held produce no cross-coupling.
- Reset mid-debounce or mid-repeat:
  - Everything clears immediately.
  - After reset, a button still held is re-qualified as a new press after the full synchroniser plus debounce latency.
- No counter wraps; each counter is bounded by its compare value.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_BTN=2.
1. Reset asserted with btn_raw=2'b11 → all outputs 0 during reset and on the first cycle after. Holding btn_raw=2'b11 after reset → btn_level=2'b11 after 5 edges, btn_press=2'b11 for exactly 1 cycle, btn_release never asserts.
2. Bounce on btn_raw[0]: high 3 cycles, low 1, high 2, low 1, then high steady → btn_level[0] rises only 5 edges after the steady high begins; exactly one btn_press[0] pulse; no btn_release[0].
3. Hold btn_raw[1] for 40 cycles after qualification → btn_repeat[1] at +10, +13, +16, … cycles after the press cycle (10 pulses in 40 cycles). btn_event[1] = press plus repeats.
4. Release btn_raw[1] mid-repeat → btn_release[1] pulses 5 edges after release and btn_level[1]=0 in that cycle. No btn_repeat[1] after btn_level falls. A 3-cycle low glitch while held produces no release.
5. Staggered: press btn 0, press btn 1 two cycles later, release btn 0 → btn_press/btn_release strobes per bit are offset by exactly the stimulus offsets, and btn_repeat[1] timing is unaffected by btn 0.
6. Assert reset while btn 0 is held and 5 cycles into the repeat phase → outputs clear immediately. After reset with btn still held: new btn_press after 5 edges, then first repeat 10 cycles after it.
